// File: rtl/apple2_disk_pkg.sv
// Shared definitions for the Apple II floppy track buffer synchroniser.
package apple2_disk_pkg;

  localparam int SECTOR_BYTES    = 512;
  localparam int DEFAULT_SECTORS = 13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_SCAN = 3'd1,
    WR_REQ  = 3'd2,
    WR_XFER = 3'd3,
    RD_REQ  = 3'd4,
    RD_XFER = 3'd5
  } fdd_state_e;

endpackage

// File: rtl/fdd_track_sync.sv
// Keeps the floppy track buffer in step with the SD card image: writes back
// modified sectors of the old track, then loads every sector of the new one.
module fdd_track_sync
  import apple2_disk_pkg::*;
#(
  parameter int SECTORS = DEFAULT_SECTORS,
  parameter int TRACK_W = 6
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_present,
  input  logic               img_readonly,
  input  logic               fd_write_disk,
  input  logic [12:0]        fd_track_addr,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  output logic [3:0]         track_sec,
  output logic               cpu_wait,
  output logic [SECTORS-1:0] dirty
);

  localparam int                 SEC_LSB  = $clog2(SECTOR_BYTES);
  localparam logic [3:0]         LAST_SEC = 4'(SECTORS - 1);
  localparam logic [SECTORS-1:0] ONE_BIT  = {{(SECTORS-1){1'b0}}, 1'b1};

  // Index of the lowest set bit; zero when the mask is empty.
  function automatic logic [3:0] lowest_set(input logic [SECTORS-1:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = SECTORS - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = 4'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Image LBA of sector s of track t, never wrapping below 32 bits.
  function automatic logic [31:0] lba_of(input logic [TRACK_W-1:0] t, input logic [3:0] s);
    return (32'(SECTORS) * {{(32-TRACK_W){1'b0}}, t}) + {28'd0, s};
  endfunction

  fdd_state_e         state_q, state_d;
  logic [TRACK_W-1:0] cur_track_q, cur_track_d;
  logic               mount_q, mount_d;
  logic [SECTORS-1:0] dirty_q, dirty_d;
  logic [3:0]         track_sec_q, track_sec_d;
  logic [31:0]        sd_lba_q, sd_lba_d;
  logic               sd_rd_q, sd_rd_d;
  logic               sd_wr_q, sd_wr_d;
  logic               sd_ack_q, sd_ack_d;

  logic               ack_rise;
  logic               ack_fall;
  logic               trigger;
  logic               wr_valid;
  logic [3:0]         wr_idx;
  logic [SECTORS-1:0] dirty_w;
  logic [3:0]         low_sec;
  logic               load_start;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^fd_track_addr[SEC_LSB-1:0];
  assign low_sec          = lowest_set(dirty_q);

  // Derived events: ack edges, load trigger and the dirty mask including this cycle's write.
  always_comb begin
    sd_ack_d = sd_ack;
    ack_rise = sd_ack & ~sd_ack_q;
    ack_fall = ~sd_ack & sd_ack_q;
    trigger  = (track != cur_track_q) | mount_q;
    wr_idx   = fd_track_addr[SEC_LSB +: 4];
    wr_valid = fd_write_disk & ({28'd0, wr_idx} < 32'(SECTORS));
    if (wr_valid) begin
      dirty_w = dirty_q | (ONE_BIT << wr_idx);
    end else begin
      dirty_w = dirty_q;
    end
  end

  // Next-state logic: write-back scan, write handshakes, then full track read.
  always_comb begin
    state_d     = state_q;
    cur_track_d = cur_track_q;
    mount_d     = mount_q | img_mounted;
    dirty_d     = dirty_q;
    track_sec_d = track_sec_q;
    sd_lba_d    = sd_lba_q;
    sd_rd_d     = sd_rd_q;
    sd_wr_d     = sd_wr_q;
    load_start  = 1'b0;

    case (state_q)
      IDLE: begin
        dirty_d = dirty_w;
        if (trigger) begin
          // A fresh mount in this very cycle stays pending for the next pass.
          mount_d = img_mounted;
          if ((dirty_w != '0) && !img_readonly && !mount_q) begin
            state_d = WB_SCAN;
          end else begin
            dirty_d    = '0;
            load_start = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WB_SCAN: begin
        if (dirty_q != '0) begin
          track_sec_d = low_sec;
          sd_lba_d    = lba_of(cur_track_q, low_sec);
          sd_wr_d     = 1'b1;
          state_d     = WR_REQ;
        end else begin
          load_start = 1'b1;
        end
      end
      WR_REQ: begin
        if (ack_rise) begin
          sd_wr_d = 1'b0;
          dirty_d = dirty_q & ~(ONE_BIT << track_sec_q);
          state_d = WR_XFER;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_XFER: begin
        if (ack_fall) begin
          state_d = WB_SCAN;
        end else begin
          state_d = WR_XFER;
        end
      end
      RD_REQ: begin
        if (ack_rise) begin
          sd_rd_d  = 1'b0;
          sd_lba_d = sd_lba_q + 32'd1;
          state_d  = RD_XFER;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_XFER: begin
        if (ack_fall) begin
          track_sec_d = track_sec_q + 4'd1;
          if (track_sec_q == LAST_SEC) begin
            state_d = IDLE;
          end else begin
            sd_rd_d = 1'b1;
            state_d = RD_REQ;
          end
        end else begin
          state_d = RD_XFER;
        end
      end
      default: begin
        state_d = IDLE;
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
      end
    endcase

    // Start of a track load: latch the head track and request sector 0.
    if (load_start) begin
      cur_track_d = track;
      if (img_present) begin
        track_sec_d = 4'd0;
        sd_lba_d    = lba_of(track, 4'd0);
        sd_rd_d     = 1'b1;
        state_d     = RD_REQ;
      end else begin
        state_d = IDLE;
      end
    end else begin
      cur_track_d = cur_track_d;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_track_q <= '1;
      mount_q     <= 1'b0;
      dirty_q     <= '0;
      track_sec_q <= 4'd0;
      sd_lba_q    <= 32'd0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      sd_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_track_q <= cur_track_d;
      mount_q     <= mount_d;
      dirty_q     <= dirty_d;
      track_sec_q <= track_sec_d;
      sd_lba_q    <= sd_lba_d;
      sd_rd_q     <= sd_rd_d;
      sd_wr_q     <= sd_wr_d;
      sd_ack_q    <= sd_ack_d;
    end
  end

  // CPU stall: busy states, plus the idle cycle that takes a trigger; off in reset.
  always_comb begin
    if (!reset_n) begin
      cpu_wait = 1'b0;
    end else begin
      cpu_wait = (state_q != IDLE) | trigger;
    end
  end

  assign sd_lba    = sd_lba_q;
  assign sd_rd     = sd_rd_q;
  assign sd_wr     = sd_wr_q;
  assign track_sec = track_sec_q;
  assign dirty     = dirty_q;

endmodule

// File: tb/tb_fdd_track_sync.sv
// Self-checking bench for fdd_track_sync: a small SD responder, a request-level
// model of the expected SD traffic, and directed scenarios.
module tb_fdd_track_sync;

  localparam int S  = 13;
  localparam int TW = 6;

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic [TW-1:0] track;
  logic          img_mounted;
  logic          img_present;
  logic          img_readonly;
  logic          fd_write_disk;
  logic [12:0]   fd_track_addr;
  logic [31:0]   sd_lba;
  logic          sd_rd;
  logic          sd_wr;
  logic          sd_ack = 1'b0;
  logic [3:0]    track_sec;
  logic          cpu_wait;
  logic [S-1:0]  dirty;

  fdd_track_sync #(.SECTORS(S), .TRACK_W(TW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
    .img_mounted(img_mounted), .img_present(img_present), .img_readonly(img_readonly),
    .fd_write_disk(fd_write_disk), .fd_track_addr(fd_track_addr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .track_sec(track_sec), .cpu_wait(cpu_wait), .dirty(dirty)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct { bit wr; int lba; int sec; } req_t;
  req_t     exp_q[$];
  req_t     obs_q[$];
  int       n_pass  = 0;
  int       n_total = 0;
  int       model_cur;
  bit [S-1:0] model_dirty;
  bit       prev_req = 1'b0;
  int       sd_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int obs_lba(input int idx);
    if (idx < obs_q.size()) return obs_q[idx].lba;
    else return -1;
  endfunction

  function automatic int obs_sec(input int idx);
    if (idx < obs_q.size()) return obs_q[idx].sec;
    else return -1;
  endfunction

  function automatic int obs_wr(input int idx);
    if (idx < obs_q.size()) return int'(obs_q[idx].wr);
    else return -1;
  endfunction

  // Expected SD traffic for one track change: write-back of dirty sectors
  // (unless read-only or a mount), then every sector of the new track.
  task automatic model_load(input int nt, input bit mnt);
    if (model_dirty != '0 && !img_readonly && !mnt) begin
      for (int s = 0; s < S; s++)
        if (model_dirty[s]) exp_q.push_back('{wr: 1'b1, lba: S * model_cur + s, sec: s});
    end
    model_dirty = '0;
    model_cur   = nt;
    if (img_present) begin
      for (int i = 0; i < S; i++)
        exp_q.push_back('{wr: 1'b0, lba: S * nt + i, sec: i});
    end
  endtask

  // SD card responder: ack two cycles after a request, held for four cycles.
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      sd_ack = 1'b0;
      sd_cnt = 0;
    end else if (sd_cnt == 0) begin
      if ((sd_rd || sd_wr) && !sd_ack) sd_cnt = 1;
    end else begin
      sd_cnt++;
      if (sd_cnt == 3) sd_ack = 1'b1;
      else if (sd_cnt == 7) begin
        sd_ack = 1'b0;
        sd_cnt = 0;
      end
    end
  end

  // Compare process: every new request against the head of the expected list.
  always @(negedge clk_sys) begin
    bit req;
    req_t e;
    if (reset_n) begin
      req = sd_rd | sd_wr;
      if (req) check("rd_wr_exclusive", sd_rd & sd_wr, 0);
      if (req || sd_ack) check("cpu_wait_busy", cpu_wait, 1);
      if (req && !prev_req) begin
        obs_q.push_back('{wr: sd_wr, lba: int'(sd_lba), sec: int'(track_sec)});
        check("req_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("req_kind", sd_wr, e.wr);
          check("req_lba", sd_lba, e.lba);
          check("req_sec", track_sec, e.sec);
        end
      end
      prev_req = req;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    repeat (2) @(negedge clk_sys);
    while (cpu_wait && i < 3000) begin
      @(negedge clk_sys);
      i++;
    end
    check({name, "_idle"}, cpu_wait, 0);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_dirty"}, dirty, model_dirty);
  endtask

  task automatic disk_write(input logic [12:0] addr);
    int idx;
    fd_track_addr = addr;
    fd_write_disk = 1'b1;
    @(negedge clk_sys);
    fd_write_disk = 1'b0;
    idx = int'(addr[12:9]);
    if (idx < S) model_dirty[idx] = 1'b1;
    check("dirty_after_write", dirty, model_dirty);
  endtask

  task automatic pulse_mount();
    img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
  endtask

  initial begin
    int base;
    int k;
    track = '0; img_mounted = 1'b0; img_present = 1'b1; img_readonly = 1'b0;
    fd_write_disk = 1'b0; fd_track_addr = '0;
    model_cur = 63; model_dirty = '0;

    // Reset state, with a pending track mismatch that must not raise cpu_wait.
    repeat (3) @(negedge clk_sys);
    check("rst_sd_rd", sd_rd, 0);
    check("rst_sd_wr", sd_wr, 0);
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_dirty", dirty, 0);
    check("rst_track_sec", track_sec, 0);
    check("rst_sd_lba", sd_lba, 0);

    // Initial load of track 0 after release.
    base = obs_q.size();
    model_load(0, 1'b0);
    reset_n = 1'b1;
    wait_idle("load_t0");
    check("t0_count", obs_q.size() - base, 13);
    check("t0_first_lba", obs_lba(base), 0);

    // Track 0 -> 3: LBAs 39..51, slots 0..12.
    base = obs_q.size();
    track = 6'd3;
    model_load(3, 1'b0);
    wait_idle("load_t3");
    check("t3_count", obs_q.size() - base, 13);
    check("t3_first_lba", obs_lba(base), 39);
    check("t3_first_sec", obs_sec(base), 0);
    check("t3_last_lba", obs_lba(base + 12), 51);
    check("t3_last_sec", obs_sec(base + 12), 12);

    // Track 5, two writes, then track 6: write-back 67, 77 then reads 78..90.
    track = 6'd5;
    model_load(5, 1'b0);
    wait_idle("load_t5");
    disk_write(13'h0400);
    disk_write(13'h1800);
    check("dirty_two_sectors", dirty, 13'h1004);
    base = obs_q.size();
    track = 6'd6;
    model_load(6, 1'b0);
    wait_idle("wb_t6");
    check("wb_count", obs_q.size() - base, 15);
    check("wb0_is_write", obs_wr(base), 1);
    check("wb0_lba", obs_lba(base), 67);
    check("wb1_lba", obs_lba(base + 1), 77);
    check("wb_rd_first_kind", obs_wr(base + 2), 0);
    check("wb_rd_first_lba", obs_lba(base + 2), 78);
    check("wb_rd_last_lba", obs_lba(base + 14), 90);
    check("wb_dirty_clear", dirty, 0);

    // Same with a read-only image: dirty discarded, reads only.
    img_readonly = 1'b1;
    track = 6'd5;
    model_load(5, 1'b0);
    wait_idle("ro_t5");
    disk_write(13'h0400);
    disk_write(13'h1800);
    base = obs_q.size();
    track = 6'd6;
    model_load(6, 1'b0);
    wait_idle("ro_t6");
    check("ro_count", obs_q.size() - base, 13);
    check("ro_first_kind", obs_wr(base), 0);
    check("ro_first_lba", obs_lba(base), 78);
    check("ro_dirty_clear", dirty, 0);
    img_readonly = 1'b0;

    // Sector index beyond the track is ignored.
    disk_write(13'h0200);
    check("dirty_sector1", dirty, 13'h0002);
    disk_write(13'h1A00);
    check("dirty_sector13_ignored", dirty, 13'h0002);
    disk_write(13'h1E00);

    // Mount discards dirty data; a second mount during a read reloads again.
    base = obs_q.size();
    pulse_mount();
    model_load(6, 1'b1);
    k = 0;
    while (!(obs_q.size() >= base + 3 && sd_ack && !sd_rd) && k < 500) begin
      @(negedge clk_sys);
      k++;
    end
    check("reach_rd_xfer", obs_q.size() >= base + 3 && sd_ack && !sd_rd, 1);
    pulse_mount();
    model_load(6, 1'b1);
    wait_idle("mount_reload");
    check("mount_count", obs_q.size() - base, 26);
    check("mount_second_lba", obs_lba(base + 13), 78);
    check("mount_writes", obs_wr(base), 0);

    // No image: track change latches the track without any SD request.
    img_present = 1'b0;
    base = obs_q.size();
    track = 6'd9;
    model_load(9, 1'b0);
    wait_idle("absent");
    check("absent_count", obs_q.size() - base, 0);
    img_present = 1'b1;

    // Reset while a read request is pending, then a fresh reload.
    base = obs_q.size();
    track = 6'd2;
    model_load(2, 1'b0);
    k = 0;
    while (!(obs_q.size() >= base + 2 && sd_rd) && k < 500) begin
      @(negedge clk_sys);
      k++;
    end
    check("reach_rd_req", obs_q.size() >= base + 2 && sd_rd, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_sd_rd", sd_rd, 0);
    check("midrst_cpu_wait", cpu_wait, 0);
    check("midrst_sd_lba", sd_lba, 0);
    exp_q.delete();
    model_cur = 63;
    model_dirty = '0;
    repeat (2) @(negedge clk_sys);
    base = obs_q.size();
    model_load(2, 1'b0);
    reset_n = 1'b1;
    wait_idle("reload_t2");
    check("reload_count", obs_q.size() - base, 13);
    check("reload_first_lba", obs_lba(base), 26);
    check("reload_last_lba", obs_lba(base + 12), 38);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fdd_track_sync.md
FDD_TRACK_SYNC -- requirements
Module: fdd_track_sync

Interface
REQ-001 SHALL have parameter SECTORS, default 13: 512-byte sectors per track.
REQ-002 SHALL have parameter TRACK_W, default 6: width of the track number.
REQ-003 SHALL have port clk_sys, input, 1: the single clock; every register is clocked by its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port track, input, TRACK_W: track under the drive head.
REQ-006 SHALL have port img_mounted, input, 1: one-cycle pulse on a new image mount.
REQ-007 SHALL have port img_present, input, 1: image size is nonzero.
REQ-008 SHALL have port img_readonly, input, 1: image is write-protected.
REQ-009 SHALL have port fd_write_disk, input, 1: the disk core writes a byte into the track buffer.
REQ-010 SHALL have port fd_track_addr, input, 13: buffer byte address; bits [12:9] are the sector index.
REQ-011 SHALL have port sd_lba, output, 32: sector LBA presented to the SD interface.
REQ-012 SHALL have port sd_rd, output, 1: read request to the SD interface.
REQ-013 SHALL have port sd_wr, output, 1: write request to the SD interface.
REQ-014 SHALL have port sd_ack, input, 1: SD acknowledge; high for the whole 512-byte transfer.
REQ-015 SHALL have port track_sec, output, 4: sector slot of the track buffer currently being transferred.
REQ-016 SHALL have port cpu_wait, output, 1: stall request to the CPU.
REQ-017 SHALL have port dirty, output, SECTORS: per-sector modified mask.

Function
REQ-018 SHALL implement states IDLE, WB_SCAN, WR_REQ, WR_XFER, RD_REQ, RD_XFER.
REQ-019 SHALL track cur_track; a load trigger is (track != cur_track) or a pending mount flag, evaluated only in IDLE.
REQ-020 SHALL, on an img_mounted pulse in any state, set the mount flag; the flag clears when IDLE consumes it.
REQ-021 SHALL, in IDLE, set dirty[fd_track_addr[12:9]] on fd_write_disk, provided that index < SECTORS; indices >= SECTORS are ignored.
REQ-022 SHALL, on a trigger when dirty != 0, img_readonly = 0 and the trigger is not a mount, go to WB_SCAN; otherwise clear dirty and go to RD_REQ.
REQ-023 SHALL, in WB_SCAN, pick the lowest set dirty bit s, set track_sec = s and sd_lba = SECTORS*cur_track + s, then go to WR_REQ; when dirty == 0, go to RD_REQ.
REQ-024 SHALL, in WR_REQ, assert sd_wr; on the rising edge of sd_ack, drop sd_wr, clear dirty[s] and go to WR_XFER.
REQ-025 SHALL, in WR_XFER, return to WB_SCAN on the falling edge of sd_ack.
REQ-026 SHALL, on entry to RD_REQ: set cur_track = track; if img_present = 0, return to IDLE with no SD request; otherwise set track_sec = 0 and sd_lba = SECTORS*track.
REQ-027 SHALL, in RD_REQ, hold sd_rd high; on the rising edge of sd_ack, drop sd_rd, increment sd_lba and go to RD_XFER.
REQ-028 SHALL, in RD_XFER, on the falling edge of sd_ack, increment track_sec; when the completed sector is SECTORS-1, go to IDLE, else go to RD_REQ.
REQ-029 SHALL keep sd_rd and sd_wr mutually exclusive and never both high.
REQ-030 SHALL never drop an sd_rd or sd_wr request before sd_ack rises.
REQ-031 SHALL drive cpu_wait high in every state except IDLE, and high in the IDLE cycle in which a trigger is taken.
REQ-032 SHALL detect sd_ack edges with one registered copy of sd_ack; edge detection adds one cycle of latency.
REQ-033 SHALL compute the LBA as SECTORS*track zero-extended to 32 bits, with no wrap.
REQ-034 SHALL treat a track change during a transfer as follows: the transfer completes, and the new track is seen as a trigger on return to IDLE.

Reset
REQ-035 SHALL, while reset_n = 0, immediately force: state IDLE, sd_rd = 0, sd_wr = 0, cpu_wait = 0, dirty = 0, track_sec = 0, sd_lba = 0, cur_track = all-ones, mount flag = 0.
REQ-036 SHALL, when reset is asserted mid-transfer, abandon the transfer without write-back and perform a fresh load of track after release.

Structure
REQ-037 SHALL place the state enumeration and the constants SECTOR_BYTES = 512 and DEFAULT_SECTORS = 13 in shared package apple2_disk_pkg.
REQ-038 SHALL be a single module with no sub-modules; the lowest-set-bit selection is an internal function.

Verification
REQ-039 SHALL cover: track 0 -> 3 with img_present = 1 -> 13 sd_rd handshakes, LBAs 39..51, track_sec 0..12, cpu_wait low after the last ack falls.
REQ-040 SHALL cover: writes to addrs 0x0400 and 0x1800 on track 5, then track -> 6 -> sd_wr at LBA 67 then 77, then reads at LBAs 78..90; dirty = 0 at the end.
REQ-041 SHALL cover: same as REQ-040 with img_readonly = 1 -> no sd_wr, dirty cleared, reads only.
REQ-042 SHALL cover: write to addr 0x1A00 (sector 13) -> dirty unchanged.
REQ-043 SHALL cover: img_mounted pulse during RD_XFER -> a second full 13-sector load of the same track follows immediately.
REQ-044 SHALL cover: reset_n low mid-RD_REQ -> sd_rd and cpu_wait low in the same cycle; after release a full reload of the current track.
